// File: rtl/rnd_rx_pkg.sv
// Shared types and defaults for the remote TRNG byte receiver.
// Holds the link FSM encoding, counter limits and parameter defaults.
package rnd_rx_pkg;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        RUN       = 2'd1,
        HALT      = 2'd2
    } state_e;

    localparam logic [15:0] OVF_MAX         = 16'hFFFF;
    localparam int          FIFO_DEPTH_DEF  = 16;
    localparam int          REP_LIMIT_DEF   = 8;
    localparam int          SYNC_STAGES_DEF = 2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == OVF_MAX) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/rnd_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO with flush.
// A push while full is accepted only when a pop happens in the same cycle.
module rnd_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [7:0]    i_data,
    output logic [7:0]    o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create ordering races.
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; the count and pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rnd_rx.sv
// Receiver for an asynchronous parallel TRNG byte stream: synchronizers,
// strobe edge capture, link FSM, repetition health test and overflow counting.
module rnd_rx
    import rnd_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int REP_LIMIT   = REP_LIMIT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_strb,
    input  logic [7:0]  rx_data,
    input  logic        rx_link_rstn,
    input  logic        clr,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] ovf_cnt,
    output logic        rep_err,
    output logic        link_up
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [SYNC_STAGES-1:0] r_strb_sync;
    logic [SYNC_STAGES-1:0] r_link_sync;
    logic [7:0]             r_data_sync [SYNC_STAGES];
    logic                   r_strb_d;
    logic                   r_cap_vld;
    logic [7:0]             r_cap_data;
    logic [RW-1:0]          r_rep_cnt;
    logic [7:0]             r_last;
    logic                   r_have_last;
    logic [15:0]            r_ovf;
    logic                   r_rep_err;
    state_e                 r_state;
    state_e                 w_state_nxt;

    logic                   w_strb_s;
    logic                   w_link_s;
    logic                   w_run;
    logic                   w_flush;
    logic                   w_cap;
    logic [RW-1:0]          w_rep_next;
    logic                   w_rep_hit;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [7:0]             w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [AW:0]            w_count;

    assign w_strb_s = r_strb_sync[SYNC_STAGES-1];
    assign w_link_s = r_link_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_strb_sync <= '0;
            r_link_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
            r_strb_d    <= 1'b0;
            r_cap_vld   <= 1'b0;
            r_cap_data  <= '0;
        end else begin
            r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], rx_strb};
            r_link_sync <= {r_link_sync[SYNC_STAGES-2:0], rx_link_rstn};
            r_data_sync[0] <= rx_data;
            for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
            r_strb_d    <= w_strb_s;
            // Edge is registered once more so the health test sees a clean capture stage.
            r_cap_vld   <= w_strb_s & ~r_strb_d & w_run;
            r_cap_data  <= r_data_sync[SYNC_STAGES-1];
        end
    end

    // Capture stage: clr and non-RUN states discard the byte.
    assign w_cap      = r_cap_vld & w_run & ~clr;
    assign w_rep_next = (r_have_last && r_cap_data == r_last) ? r_rep_cnt + 1'b1 : RW'(1);
    assign w_rep_hit  = w_cap & (w_rep_next == RW'(REP_LIMIT));
    assign w_pop      = m_valid & m_ready;
    assign w_push     = w_cap & ~w_rep_hit & (~w_full | w_pop);
    assign w_drop     = w_cap & ~w_rep_hit & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= LINK_DOWN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LINK_DOWN: if (w_link_s) w_state_nxt = RUN;
            RUN: begin
                if (w_rep_hit)      w_state_nxt = HALT;
                else if (!w_link_s) w_state_nxt = LINK_DOWN;
            end
            HALT:      if (clr) w_state_nxt = LINK_DOWN;
            default:   w_state_nxt = LINK_DOWN;
        endcase
    end

    always_comb begin
        w_run   = (r_state == RUN);
        w_flush = (w_state_nxt != r_state) && (w_state_nxt != RUN);
        link_up = w_run;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rep_cnt   <= '0;
            r_last      <= '0;
            r_have_last <= 1'b0;
            r_ovf       <= '0;
            r_rep_err   <= 1'b0;
        end else begin
            if (clr || w_flush) begin
                r_rep_cnt   <= '0;
                r_have_last <= 1'b0;
            end else if (w_cap) begin
                r_rep_cnt   <= w_rep_next;
                r_last      <= r_cap_data;
                r_have_last <= 1'b1;
            end
            if (clr)         r_ovf <= '0;
            else if (w_drop) r_ovf <= sat_inc16(r_ovf);
            if (clr)            r_rep_err <= 1'b0;
            else if (w_rep_hit) r_rep_err <= 1'b1;
        end
    end

    rnd_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (r_cap_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign m_valid = (w_count != '0);
    assign m_data  = w_empty ? 8'h00 : w_head;
    assign ovf_cnt = r_ovf;
    assign rep_err = r_rep_err;

endmodule

// File: tb/tb_rnd_rx.sv
// Directed bench for rnd_rx: stimulus pushes expected bytes into a queue,
// a negedge monitor pops and compares every accepted output byte.
module tb_rnd_rx;

    logic        clk;
    logic        rstn;
    logic        rx_strb;
    logic [7:0]  rx_data;
    logic        rx_link_rstn;
    logic        clr;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] ovf_cnt;
    logic        rep_err;
    logic        link_up;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [7:0]  exp_q[$];

    rnd_rx dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_strb      (rx_strb),
        .rx_data      (rx_data),
        .rx_link_rstn (rx_link_rstn),
        .clr          (clr),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .ovf_cnt      (ovf_cnt),
        .rep_err      (rep_err),
        .link_up      (link_up)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Strobe high for 3 cycles, low for 3; the byte is stored 4 edges after the first high sample.
    task automatic strobe(input logic [7:0] b);
        rx_data = b;
        rx_strb = 1'b1;
        tick(3);
        rx_strb = 1'b0;
        tick(3);
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && m_valid && m_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL sb_unexpected: got 0x%02h expected no output", m_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        n_miss++;
                        $display("FAIL sb_data: got 0x%02h expected 0x%02h", m_data, e);
                    end
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; rx_strb = 1'b0; rx_data = 8'h00; rx_link_rstn = 1'b0;
        clr = 1'b0; m_ready = 1'b0;
        tick(2);
        rstn = 1'b1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data",  m_data,  8'h00);
        check("rst_ovf",     ovf_cnt, 0);
        check("rst_rep_err", rep_err, 0);
        check("rst_link_up", link_up, 0);

        // Link up, then three bytes streamed with m_ready high.
        rx_link_rstn = 1'b1;
        tick(4);
        check("link_up_run", link_up, 1);
        m_ready = 1'b1;
        exp_q.push_back(8'h11);
        rx_data = 8'h11;
        rx_strb = 1'b1;
        tick(3);
        check("mvalid_edge3", m_valid, 0);
        tick(1);
        check("mvalid_edge4", m_valid, 1);
        rx_strb = 1'b0;
        tick(3);
        exp_q.push_back(8'h22); strobe(8'h22);
        exp_q.push_back(8'h33); strobe(8'h33);
        tick(4);
        check("seq_drained", exp_q.size(), 0);

        // Overflow: 18 distinct captures into a 16-deep FIFO with no consumer.
        m_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) exp_q.push_back(8'h40 + 8'(i));
            strobe(8'h40 + 8'(i));
        end
        check("ovf_two", ovf_cnt, 2);
        check("full_valid", m_valid, 1);
        // Capture and pop in the same cycle while full: nothing dropped.
        exp_q.push_back(8'h77);
        rx_data = 8'h77;
        rx_strb = 1'b1;
        tick(3);
        rx_strb = 1'b0;
        m_ready = 1'b1;
        tick(1);
        m_ready = 1'b0;
        tick(3);
        check("ovf_no_drop", ovf_cnt, 2);
        m_ready = 1'b1;
        tick(20);
        check("ovf_drained", exp_q.size(), 0);

        // Repetition test: eight 0xA5 captures halt the link.
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) strobe(8'hA5);
        check("rep_7_ok", rep_err, 0);
        check("rep_7_valid", m_valid, 1);
        strobe(8'hA5);
        check("rep_8_err", rep_err, 1);
        check("rep_flushed", m_valid, 0);
        check("rep_halt_link", link_up, 0);
        tick(3);
        check("halt_sticky", link_up, 0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_rep_err", rep_err, 0);
        check("clr_ovf", ovf_cnt, 0);
        tick(1);
        check("clr_relink", link_up, 1);

        // Link drop with five bytes buffered.
        for (int i = 1; i <= 5; i++) strobe(8'(i));
        check("five_valid", m_valid, 1);
        rx_link_rstn = 1'b0;
        tick(3);
        check("down_link", link_up, 0);
        check("down_flush", m_valid, 0);
        m_ready = 1'b1;
        strobe(8'h99);
        tick(3);
        check("down_no_out", m_valid, 0);
        rx_link_rstn = 1'b1;
        tick(4);
        check("relink", link_up, 1);

        // Reset mid-stream.
        m_ready = 1'b0;
        strobe(8'h61);
        strobe(8'h62);
        check("pre_rst_valid", m_valid, 1);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data",  m_data,  8'h00);
        check("mid_rst_link",  link_up, 0);
        tick(4);
        m_ready = 1'b1;
        exp_q.push_back(8'h63);
        strobe(8'h63);
        tick(2);
        // clr lands on the capture cycle: byte discarded.
        rx_data = 8'h70;
        rx_strb = 1'b1;
        tick(3);
        rx_strb = 1'b0;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(4);
        check("clr_cap_drop", m_valid, 0);
        check("clr_cap_ovf", ovf_cnt, 0);
        check("final_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rnd_rx.md
RND_RX -- requirements
Module: rnd_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, FIFO depth in bytes (power of 2, 4..64).
REQ-002 The block SHALL have parameter REP_LIMIT, default 8, count of consecutive identical bytes that triggers the repetition error.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count on all rx_* inputs (2..3).
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 rx_strb  input  1  asynchronous sample strobe from the remote TRNG board.
REQ-007 rx_data  input  8  asynchronous parallel random byte; stable while rx_strb is high.
REQ-008 rx_link_rstn  input  1  asynchronous remote reset state; 1 means the remote TRNG is running.
REQ-009 clr  input  1  clears the error state and statistics; single-cycle pulse.
REQ-010 m_data  output  8  head byte of the FIFO.
REQ-011 m_valid  output  1  head byte is valid.
REQ-012 m_ready  input  1  consumer accepts the head byte.
REQ-013 ovf_cnt  output  16  count of bytes dropped because the FIFO was full.
REQ-014 rep_err  output  1  repetition health-test failure flag.
REQ-015 link_up  output  1  1 when the state is RUN.

Function
REQ-016 rx_strb, rx_data and rx_link_rstn SHALL each pass through SYNC_STAGES flops before any use.
REQ-017 rx_strb high time at the pins SHALL be at least 2 clk periods; shorter pulses are unsupported and need not be captured.
REQ-018 A capture SHALL occur on the clk cycle where the synchronized strobe is 1 and its previous registered value is 0 (rising edge), sampling the synchronized rx_data.
REQ-019 With SYNC_STAGES=2 and an empty FIFO, m_valid SHALL rise on the 4th clk edge after the first edge that samples rx_strb high.
REQ-020 The FIFO SHALL be first-word-fall-through: m_valid = (count != 0) and m_data = head byte, both registered-state derived with no combinational path from m_ready.
REQ-021 A pop SHALL occur when m_valid and m_ready are both 1; m_ready with an empty FIFO SHALL have no effect.
REQ-022 A capture with FIFO full and no pop in the same cycle SHALL drop the byte and increment ovf_cnt, saturating at 0xFFFF.
REQ-023 A capture and a pop in the same cycle SHALL both take effect, full or not, with count unchanged.
REQ-024 The FSM states SHALL be LINK_DOWN, RUN and HALT.
REQ-025 LINK_DOWN -> RUN SHALL occur when synchronized rx_link_rstn = 1.
REQ-026 RUN -> LINK_DOWN SHALL occur when synchronized rx_link_rstn = 0.
REQ-027 RUN -> HALT SHALL occur when rep_err sets.
REQ-028 HALT -> LINK_DOWN SHALL occur only on clr.
REQ-029 Captures SHALL be accepted only in RUN.
REQ-030 Entering LINK_DOWN or HALT SHALL flush the FIFO (count=0) and clear the repetition counter.
REQ-031 The repetition counter SHALL set to 1 on a capture differing from the previous captured byte and increment on an equal one; the first capture after flush counts as differing.
REQ-032 When the repetition counter reaches REP_LIMIT, the capture SHALL NOT be written and rep_err SHALL be set (sticky until clr or reset).
REQ-033 clr SHALL clear rep_err, ovf_cnt and the repetition counter.
REQ-034 clr SHALL take priority over a capture in the same cycle; that capture is discarded.
REQ-035 In HALT, rx_link_rstn changes SHALL be ignored.

Reset
REQ-036 While rstn=0 at a clk edge, the block SHALL set state=LINK_DOWN, FIFO count and pointers=0, m_valid=0, m_data=0x00, ovf_cnt=0, rep_err=0, link_up=0, and all synchronizer and edge flops=0.
REQ-037 Reset mid-transfer SHALL discard all buffered bytes; the first capture after reset SHALL require a fresh rx_strb rising edge seen in RUN.

Structure
REQ-038 Package rnd_rx_pkg SHALL hold the state encoding (LINK_DOWN=2'd0, RUN=2'd1, HALT=2'd2), OVF_MAX=16'hFFFF and the parameter defaults.
REQ-039 Sub-module rnd_rx_fifo SHALL implement the synchronous FWFT FIFO with push, pop, flush, full, empty and count.
REQ-040 Synchronizers, edge detect, FSM, the health test and counters SHALL reside in rnd_rx.

Verification
REQ-041 Link up, strobes with bytes 0x11,0x22,0x33 and m_ready=1 -> m_data sequence 0x11,0x22,0x33; m_valid rises on the 4th edge after first strobe sample.
REQ-042 m_ready=0 and 18 distinct captures with depth 16 -> 16 stored in order, ovf_cnt=2; capture and pop simultaneous when full -> no drop.
REQ-043 8 consecutive captures of 0xA5 -> rep_err=1 on the 8th, 7 bytes previously in FIFO flushed, link_up=0; clr -> rep_err=0, then RUN once link high.
REQ-044 rx_link_rstn falls with 5 bytes buffered -> FIFO empty, link_up=0 within SYNC_STAGES+1 cycles; strobes while down produce no output.
REQ-045 rstn low for 1 cycle mid-stream -> all outputs at reset values next cycle; clr coincident with capture -> byte discarded, ovf_cnt=0.
